// File: rtl/processor_pio_pkg.sv
// Shared definitions for the processor PIO blocks (input and output side).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package processor_pio_pkg;

   // Avalon word addresses of the PIO register map
   localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
   localparam logic [2:0] PIO_ADDR_SET       = 3'd1;
   localparam logic [2:0] PIO_ADDR_CLEAR     = 3'd2;
   localparam logic [2:0] PIO_ADDR_TOGGLE    = 3'd3;
   localparam logic [2:0] PIO_ADDR_PULSE_LEN = 3'd4;
   localparam logic [2:0] PIO_ADDR_PULSE     = 3'd5;

   // Width of the Avalon read-data bus
   localparam int unsigned PIO_RDATA_W = 32;

   // Timed-pulse engine states
   typedef enum logic {
      PULSE_IDLE   = 1'b0,
      PULSE_ACTIVE = 1'b1
   } pulse_state_e;

endpackage

// File: rtl/processor_pin_saida_pulse.sv
// Timed-pulse engine: holds a pin mask active for a programmed number of clocks.
// Latency: active/mask valid right after the start edge; held for exactly len clocks.
// Backpressure: none; a new start always restarts the pulse, even on the expiry edge.
module processor_pin_saida_pulse
   import processor_pio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 3,
   parameter int unsigned PULSE_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [PULSE_CNT_W-1:0] len,
   input  logic [DATA_WIDTH-1:0]  mask_in,
   output logic                   active,
   output logic [DATA_WIDTH-1:0]  mask
);

   pulse_state_e            state_q, state_d;
   logic [PULSE_CNT_W-1:0]  count_q, count_d;
   logic [DATA_WIDTH-1:0]   mask_q, mask_d;
   logic                    go;
   logic                    expire;

   // Zero length or empty mask would be a no-op pulse, so such starts are dropped
   assign go     = start && (len != '0) && (mask_in != '0);
   assign expire = (state_q == PULSE_ACTIVE) && (count_q == PULSE_CNT_W'(1));

   // State, counter and mask registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PULSE_IDLE;
         count_q <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mask_q  <= mask_d;
      end
   end

   // Next state: a valid start wins over expiry so restarts have no gap
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mask_d  = mask_q;
      if (go) begin
         state_d = PULSE_ACTIVE;
         count_d = len;
         mask_d  = mask_in;
      end else if (expire) begin
         state_d = PULSE_IDLE;
         count_d = '0;
         mask_d  = '0;
      end else if (state_q == PULSE_ACTIVE) begin
         count_d = count_q - PULSE_CNT_W'(1);
      end
   end

   // Outputs straight from flops
   always_comb begin
      active = (state_q == PULSE_ACTIVE);
      mask   = mask_q;
   end

endmodule

// File: rtl/processor_pin_saida.sv
// Avalon-MM output PIO: data register with set/clear/toggle strobes and a timed pin-inversion pulse.
// Latency: writes visible on out_port right after the write edge; readdata registered, 1 cycle.
// Backpressure: none; zero wait states, every access completes in one cycle.
module processor_pin_saida
   import processor_pio_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH  = 3,
   parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
   parameter int unsigned            PULSE_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [2:0]             address,
   input  logic                   chipselect,
   input  logic                   write_n,
   input  logic [31:0]            writedata,
   output logic [PIO_RDATA_W-1:0] readdata,
   output logic [DATA_WIDTH-1:0]  out_port
);

   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [PULSE_CNT_W-1:0] len_q, len_d;
   logic [PIO_RDATA_W-1:0] rdata_q, rdata_d;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  wd;
   logic                   pulse_start;
   logic                   pulse_active;
   logic [DATA_WIDTH-1:0]  pulse_mask;
   logic                   unused_wd;

   assign wr_en       = chipselect & ~write_n;
   assign wd          = writedata[DATA_WIDTH-1:0];
   assign pulse_start = wr_en && (address == PIO_ADDR_PULSE);
   // Upper write-data bits beyond the register widths are deliberately ignored
   assign unused_wd   = ^writedata;

   processor_pin_saida_pulse #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PULSE_CNT_W (PULSE_CNT_W)
   ) u_pulse (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (pulse_start),
      .len     (len_q),
      .mask_in (wd),
      .active  (pulse_active),
      .mask    (pulse_mask)
   );

   // Register write decode; reserved addresses fall through untouched
   always_comb begin
      data_d = data_q;
      len_d  = len_q;
      if (wr_en) begin
         case (address)
            PIO_ADDR_DATA:      data_d = wd;
            PIO_ADDR_SET:       data_d = data_q | wd;
            PIO_ADDR_CLEAR:     data_d = data_q & ~wd;
            PIO_ADDR_TOGGLE:    data_d = data_q ^ wd;
            PIO_ADDR_PULSE_LEN: len_d  = writedata[PULSE_CNT_W-1:0];
            default: ;
         endcase
      end
   end

   // Read mux, sampled every clock regardless of any read strobe
   always_comb begin
      rdata_d = '0;
      case (address)
         PIO_ADDR_DATA:      rdata_d[DATA_WIDTH-1:0]  = data_q;
         PIO_ADDR_PULSE_LEN: rdata_d[PULSE_CNT_W-1:0] = len_q;
         PIO_ADDR_PULSE: begin
            rdata_d[DATA_WIDTH-1:0]  = pulse_mask;
            rdata_d[PIO_RDATA_W-1]   = pulse_active;
         end
         default: ;
      endcase
   end

   // Data, pulse-length and read-data registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= RESET_VALUE;
         len_q   <= '0;
         rdata_q <= '0;
      end else begin
         data_q  <= data_d;
         len_q   <= len_d;
         rdata_q <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   // Pins are the raw data with the pulse mask inverted on top; flops only, no bus path
   assign out_port = data_q ^ (pulse_active ? pulse_mask : '0);

endmodule

// File: doc/processor_pin_saida.md
# processor_pin_saida

Avalon-MM slave output PIO: the write-side counterpart of the system's input PIO, driving `out_port` from a CPU-written data register. Besides plain writes it provides atomic set/clear/toggle strobes and a timed-pulse engine that inverts selected pins for a programmable number of clocks and then restores them. It sits on the processor's Avalon data bus beside the input PIO and drives board pins directly.

## Interface
- `DATA_WIDTH`, 3: number of output pins (1..32).
- `RESET_VALUE`, 0: value of the data register after reset.
- `PULSE_CNT_W`, 16: width of the pulse-length register and counter.

- `clk`  input  1  system clock; all state on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `address`  input  3  register select.
- `chipselect`  input  1  slave selected.
- `write_n`  input  1  active-low write strobe; write = `chipselect & ~write_n`.
- `writedata`  input  32  write data; bits above the register width are ignored.
- `readdata`  output  32  registered read data, zero-extended.
- `out_port`  output  DATA_WIDTH  pin drive.

## Operation
- Register map, word addresses:
  - 0 DATA (R/W): data register.
  - 1 SET (W): `data |= wd`.
  - 2 CLEAR (W): `data &= ~wd`.
  - 3 TOGGLE (W): `data ^= wd`.
  - 4 PULSE_LEN (R/W): `PULSE_CNT_W` bits; reset 0.
  - 5 PULSE: write starts a pulse with mask = `wd[DATA_WIDTH-1:0]`. Read returns `{active, 0…, mask}`, with `active` in bit 31 and the mask in the low bits; mask reads 0 when idle.
  - 6, 7: reserved; reads return 0 and writes are ignored.
- Reads of addresses 1–3 return 0.
- Output equation: `out_port = data ^ (active ? mask : 0)`.
- DATA reads return the raw data register, not the pulse-modified value.
- Pulse FSM, two states:
  - IDLE→ACTIVE: a PULSE write with `PULSE_LEN != 0` and a nonzero mask. Load `count = PULSE_LEN` and latch the mask.
  - In ACTIVE, `count` decrements every clock.
  - ACTIVE→IDLE: on the edge where `count == 1`. Clear the mask.
  - A PULSE write with `PULSE_LEN == 0` or mask == 0 is ignored and leaves the FSM unchanged.
- Boundary rules:
  - PULSE write while ACTIVE: restarts. New mask and count load, and the old pulse ends without a gap.
  - PULSE write on the same edge as expiry: the write wins and the FSM stays ACTIVE with the new values.
  - DATA/SET/CLEAR/TOGGLE writes during ACTIVE modify `data` only. The pulse XOR continues over the new value.
  - Writing PULSE_LEN during ACTIVE does not affect the running count.
- Asserting `reset_n` mid-pulse aborts the pulse immediately.

## Timing
- Reset values: data = `RESET_VALUE`, PULSE_LEN = 0, FSM IDLE, mask = 0, count = 0, `readdata` = 0, so `out_port = RESET_VALUE`.
- Writes take effect at the sampling edge. `out_port` reflects the write immediately after that edge, with zero wait states.
- `readdata` is registered every clock from the address mux, independent of the read strobe, giving 1-cycle read latency.
- Pulse written at edge N with length L: the pins are inverted from after edge N until after edge N+L, exactly L clocks.
- `out_port` is a pure XOR of flops, with no combinational path from bus inputs.

## Structure
- Shared package `processor_pio_pkg`:
  - address constants `PIO_ADDR_DATA`…`PIO_ADDR_PULSE`;
  - pulse FSM state enum;
  - read-data width constant (32).
  The input PIO uses the same package.
- One sub-module, `processor_pin_saida_pulse`, contains the counter, FSM and mask register. Ports: `clk`, `reset_n`, `start`, `len`, `mask_in`, `active`, `mask`.
- The top level holds the data register, write decode, read mux and output XOR.

## Test plan
- Reset: hold `reset_n` = 0 with `RESET_VALUE` = 3'b101 -> `out_port` = 101, `readdata` = 0, PULSE reads 0.
- Bus ops: write DATA = 3'b010, then SET 3'b001, CLEAR 3'b010, TOGGLE 3'b111 -> `out_port` sequence 010, 011, 001, 110, each visible the cycle after the write edge. Read DATA -> 0x6, one cycle after the address is presented.
- Pulse: PULSE_LEN = 4, DATA = 000, PULSE mask 3'b100 -> `out_port` = 100 for exactly 4 clocks, then 000. PULSE reads 0x8000_0004 during the pulse and 0 after.
- Restart and collision: PULSE_LEN = 5, then a mask 001 pulse, then a mask 010 pulse 2 clocks later -> 010 for 5 clocks with no gap. Repeat with the second write on the expiry edge -> continuous pulse.
- Ignored and overlap cases: PULSE with PULSE_LEN = 0 -> no change. SET 3'b100 during an active mask-100 pulse -> `out_port` bit 2 = 0 until expiry, then 1.
- Reset mid-pulse: assert `reset_n` asynchronously during ACTIVE -> `out_port` returns to `RESET_VALUE` immediately, and the FSM is IDLE after release.
